mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Memory bus controller sitting directly upstream of the 10-bit memory buffer register. It accepts single read/write commands from the control unit and runs a req/ack handshake with the memory array. On reads it captures the returned word and drives the MBR's data and load-select inputs for exactly one cycle. It reports completion or bus timeout back to the control unit.

## Interface
- DATA_W, 10, word width; matches MBR width
- ADDR_W, 10, address width
- TIMEOUT, 15, maximum REQ cycles without mem_ack before abort (legal 1..255)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- rw  in  1  1 = write, 0 = read; sampled with start
- addr_in  in  ADDR_W  command address; sampled with start
- wdata_in  in  DATA_W  write data; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle timeout pulse
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack high
- mem_ack  in  1  memory acknowledge
- mbr_data  out  DATA_W  captured read word, to MBR data input
- mbr_load  out  1  MBR select (load) strobe

## Operation
- States: IDLE, REQ, FIN, ERR. Moore outputs only: all outputs come from registers or the state register; no combinational path from any input to any output.
- IDLE: busy=0. If start=1 at an edge, latch addr_in→mem_addr, wdata_in→mem_wdata, rw→mem_we, clear wait counter, go to REQ.
- REQ: mem_req=1, busy=1. At each edge:
  - mem_ack=1 → mem_req deasserted; if mem_we=0, mem_rdata→mbr_data; go to FIN.
  - else if counter = TIMEOUT-1 → go to ERR.
  - else increment counter.
- FIN: done=1; mbr_load=1 only when the command was a read; mbr_load=0 for writes. Next edge → IDLE.
- ERR: error=1, done=0, mbr_load=0, mbr_data unchanged. Next edge → IDLE.
- mbr_data holds its value outside read captures. A write never alters mbr_data.
- start outside IDLE is ignored; no queuing. mem_ack outside REQ is ignored.
- Counter is 8 bits and never wraps, because TIMEOUT ≤ 255.
- If mem_ack and the timeout count coincide in the same cycle, ack wins and the command completes normally.

## Timing
- Reset (reset=0): asynchronous. State=IDLE, and busy, done, error, mem_req, mem_we, mbr_load = 0. mem_addr, mem_wdata, mbr_data = 0. Counter = 0.
- Reset mid-transaction aborts immediately: mem_req drops without waiting for the edge, and no done or error pulse is produced.
- Start sampled at edge E0 → mem_req, busy high after E0.
- mem_ack sampled high at edge En (n ≥ 1) → FIN after En: done/mbr_load high for one cycle, mem_req low. Then IDLE after En+1.
- Minimum start-to-done latency is 1 cycle of REQ plus 1 cycle: done is visible after E1 when ack is high in the first REQ cycle.
- No ack → REQ lasts exactly TIMEOUT cycles. error is high during the cycle after edge E(TIMEOUT) and busy is low after E(TIMEOUT+1).
- Back-to-back: the earliest next accepted start is the edge at which the state is IDLE, i.e. the edge following the FIN/ERR cycle.
- mbr_data is stable during the mbr_load cycle, so the MBR captures it at the edge ending FIN.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, then release → all outputs 0, busy=0; start=0 keeps the block idle.
- Zero-wait read: start, rw=0, addr 0x05A; memory acks in the first REQ cycle with rdata 0x2C3 → done and mbr_load high for one cycle with mbr_data=0x2C3, 2 edges after start; MBR then holds 0x2C3.
- Write with 3 wait cycles: start, rw=1, addr 0x3FF, wdata 0x155 → mem_we=1 and mem_wdata=0x155 held for 4 REQ cycles; done pulses once; mbr_load stays 0; mbr_data keeps its prior value.
- Timeout: TIMEOUT=15, read, mem_ack never asserted → mem_req high exactly 15 cycles, a single error pulse, no done, mbr_data unchanged; the next start is accepted.
- Ignored inputs: start pulsed during REQ, and a stray mem_ack in IDLE → no extra transaction, no state change.
- Reset mid-operation: reset=0 during the 2nd REQ cycle → mem_req drops immediately, no done/error pulse, mbr_data=0; a normal read completes after reset is released.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-command req/ack memory bus master.
// Read words are captured and presented to the MBR with a one-cycle load.
module mem_bus_ctrl #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mbr_data,
  output logic              mbr_load
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       take;
  logic       hit;
  logic       last;

  assign take = (state == IDLE) && start;
  assign hit  = (state == REQ) && mem_ack;
  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack beats timeout when both land on the same edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt = FIN;
        end else if (last) begin
          state_nxt = ERR;
        end
      end
      FIN: state_nxt = IDLE;
      ERR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cnt       <= 8'd0;
    end else if (take) begin
      mem_addr  <= addr_in;
      mem_wdata <= wdata_in;
      mem_we    <= rw;
      cnt       <= 8'd0;
    end else if (state == REQ && !mem_ack && !last) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mbr_data <= '0;
    end else if (hit && !mem_we) begin
      mbr_data <= mem_rdata;
    end
  end

  assign busy     = (state != IDLE);
  assign mem_req  = (state == REQ);
  assign done     = (state == FIN);
  assign error    = (state == ERR);
  assign mbr_load = (state == FIN) && !mem_we;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed scenario checks for mem_bus_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_bus_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rw;
  logic [9:0] addr_in;
  logic [9:0] wdata_in;
  logic       busy;
  logic       done;
  logic       error;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [9:0] mem_wdata;
  logic [9:0] mem_rdata;
  logic       mem_ack;
  logic [9:0] mbr_data;
  logic       mbr_load;

  int total = 0;
  int bad = 0;

  mem_bus_ctrl #(
    .DATA_W(10),
    .ADDR_W(10),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rw(rw),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .busy(busy),
    .done(done),
    .error(error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .mbr_data(mbr_data),
    .mbr_load(mbr_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    rw = 1'b0;
    addr_in = '0;
    wdata_in = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({busy, done, error, mem_req, mem_we, mbr_load} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {busy, done, error, mem_req, mem_we, mbr_load});
    end
    total++;
    if ({mem_addr, mem_wdata, mbr_data} !== 30'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0",
               {mem_addr, mem_wdata, mbr_data});
    end
    repeat (2) tick();
    total++;
    if ({busy, mem_req, done} !== 3'b000) begin
      bad++;
      $display("FAIL idle_hold got=%b exp=000", {busy, mem_req, done});
    end
  endtask

  task automatic test_read();
    start = 1'b1;
    rw = 1'b0;
    addr_in = 10'h05A;
    wdata_in = 10'h000;
    tick();
    start = 1'b0;
    total++;
    if ({busy, mem_req, mem_we, mem_addr} !== {3'b110, 10'h05A}) begin
      bad++;
      $display("FAIL rd_req got=%b/%h exp=110/05a",
               {busy, mem_req, mem_we}, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 10'h2C3;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 10'h000;
    total++;
    if ({done, mbr_load, mem_req, error} !== 4'b1100) begin
      bad++;
      $display("FAIL rd_fin got=%b exp=1100",
               {done, mbr_load, mem_req, error});
    end
    total++;
    if (mbr_data !== 10'h2C3) begin
      bad++;
      $display("FAIL rd_data got=%h exp=2c3", mbr_data);
    end
    tick();
    total++;
    if ({done, mbr_load, busy, mbr_data} !== {3'b000, 10'h2C3}) begin
      bad++;
      $display("FAIL rd_after got=%b/%h exp=000/2c3",
               {done, mbr_load, busy}, mbr_data);
    end
  endtask

  task automatic test_write_wait();
    int dones;
    dones = 0;
    start = 1'b1;
    rw = 1'b1;
    addr_in = 10'h3FF;
    wdata_in = 10'h155;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({mem_req, mem_we, mem_wdata, mem_addr} !==
          {2'b11, 10'h155, 10'h3FF}) begin
        bad++;
        $display("FAIL wr_req%0d got=%b/%h/%h exp=11/155/3ff", i,
                 {mem_req, mem_we}, mem_wdata, mem_addr);
      end
      if (done) dones++;
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({done, mbr_load, mem_req} !== 3'b100) begin
      bad++;
      $display("FAIL wr_fin got=%b exp=100", {done, mbr_load, mem_req});
    end
    total++;
    if (mbr_data !== 10'h2C3) begin
      bad++;
      $display("FAIL wr_mbr got=%h exp=2c3", mbr_data);
    end
    tick();
    if (done) dones++;
    total++;
    if (dones !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_pulse got=%0d/%b exp=0/0", dones, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    int dones;
    n = 0;
    dones = 0;
    start = 1'b1;
    rw = 1'b0;
    addr_in = 10'h011;
    tick();
    start = 1'b0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (done || error) dones++;
      tick();
    end
    total++;
    if (n !== 15 || dones !== 0) begin
      bad++;
      $display("FAIL to_len got=%0d/%0d exp=15/0", n, dones);
    end
    total++;
    if ({error, done, mbr_load, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL to_err got=%b exp=1001",
               {error, done, mbr_load, busy});
    end
    total++;
    if (mbr_data !== 10'h2C3) begin
      bad++;
      $display("FAIL to_mbr got=%h exp=2c3", mbr_data);
    end
    tick();
    total++;
    if ({error, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL to_idle got=%b exp=000", {error, busy, done});
    end
    start = 1'b1;
    addr_in = 10'h012;
    tick();
    start = 1'b0;
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 10'h012}) begin
      bad++;
      $display("FAIL to_next got=%b/%h exp=1/012", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 10'h0F0;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({done, mbr_load, mbr_data} !== {2'b11, 10'h0F0}) begin
      bad++;
      $display("FAIL to_rd got=%b/%h exp=11/0f0",
               {done, mbr_load}, mbr_data);
    end
    tick();
  endtask

  task automatic test_ignored();
    start = 1'b1;
    rw = 1'b0;
    addr_in = 10'h100;
    tick();
    rw = 1'b1;
    addr_in = 10'h222;
    tick();
    start = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 10'h100}) begin
      bad++;
      $display("FAIL ign_start got=%b/%h exp=10/100",
               {mem_req, mem_we}, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 10'h1A5;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({done, mbr_load, mbr_data} !== {2'b11, 10'h1A5}) begin
      bad++;
      $display("FAIL ign_rd got=%b/%h exp=11/1a5",
               {done, mbr_load}, mbr_data);
    end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 10'h3AA;
    tick();
    tick();
    mem_ack = 1'b0;
    total++;
    if ({busy, mem_req, done, mbr_load, mbr_data} !==
        {4'b0000, 10'h1A5}) begin
      bad++;
      $display("FAIL ign_ack got=%b/%h exp=0000/1a5",
               {busy, mem_req, done, mbr_load}, mbr_data);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    rw = 1'b0;
    addr_in = 10'h0AB;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({mem_req, busy, done, error, mbr_data} !== {4'b0000, 10'h000}) begin
      bad++;
      $display("FAIL rst_mid got=%b/%h exp=0000/000",
               {mem_req, busy, done, error}, mbr_data);
    end
    tick();
    total++;
    if ({done, error, mem_req} !== 3'b000) begin
      bad++;
      $display("FAIL rst_hold got=%b exp=000", {done, error, mem_req});
    end
    reset = 1'b1;
    tick();
    start = 1'b1;
    addr_in = 10'h0CD;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 10'h3C3;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({done, mbr_load, mbr_data, mem_addr} !==
        {2'b11, 10'h3C3, 10'h0CD}) begin
      bad++;
      $display("FAIL rst_rd got=%b/%h/%h exp=11/3c3/0cd",
               {done, mbr_load}, mbr_data, mem_addr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
